// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller and the ALU.
// Optional feature macro: MC_MEM_WAIT_EN (memory handshake stalls).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU operation codes; 3'b011 is reserved and never produced
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    aluop_t     aluop;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop/funct to the ALU operation code.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       illegal_funct
);

  always_comb begin
    alucont       = ALU_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucont = ALU_ADD;
          F_SUB:   alucont = ALU_SUB;
          F_AND:   alucont = ALU_AND;
          F_OR:    alucont = ALU_OR;
          F_SLT:   alucont = ALU_SLT;
          // unknown funct falls back to add and is flagged
          default: illegal_funct = 1'b1;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM (Moore) with ALU decode sub-block.
// Define MC_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [2:0] alucont,
  output logic       illegal
);

  state_t     state, next;
  ctrl_t      c;
  logic       bad_funct_q;
  logic       illegal_funct;
  logic [2:0] dec_alucont;
  logic       mem_go;

`ifdef MC_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  // single-cycle memory: handshake is tied off but kept referenced
  assign mem_go = 1'b1 | mem_ready;
`endif

  mc_aludec u_aludec (
    .aluop         (c.aluop),
    .funct         (funct),
    .alucont       (dec_alucont),
    .illegal_funct (illegal_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // remembers a bad funct from RTYPEEX so the writeback can be squashed
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  bad_funct_q <= 1'b0;
    else if (state == S_RTYPEEX) bad_funct_q <= illegal_funct;
  end

  always_comb begin
    next = state;
    case (state)
      S_FETCH:   next = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE:     next = S_RTYPEEX;
          OP_BEQ:       next = S_BEQEX;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JEX;
          default:      next = S_FETCH;
        endcase
      end
      S_MEMADR:  next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next = mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWR:   next = mem_go ? S_FETCH : S_MEMWR;
      S_RTYPEEX: next = S_RTYPEWB;
      S_ADDIEX:  next = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: next = S_FETCH;
      default:   next = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.irwrite = mem_go;
        c.pcwrite = mem_go;
        c.alusrcb = 2'b01;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = ~bad_funct_q;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
  end

  // outputs are squashed combinationally so no strobe survives reset assertion
  always_comb begin
    pcen     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    pcsrc    = 2'b00;
    alucont  = ALU_ADD;
    illegal  = 1'b0;
    if (!reset) begin
      pcen     = c.pcwrite | (c.branch & zero);
      memwrite = c.memwrite;
      irwrite  = c.irwrite;
      regwrite = c.regwrite;
      alusrca  = c.alusrca;
      alusrcb  = c.alusrcb;
      iord     = c.iord;
      memtoreg = c.memtoreg;
      regdst   = c.regdst;
      pcsrc    = c.pcsrc;
      alucont  = dec_alucont;
      illegal  = ((state == S_DECODE) && !op_supported(op)) ||
                 ((state == S_RTYPEEX) && illegal_funct);
    end
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have the following ports, one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- op  in  6  instruction opcode (instr[31:26])
- funct  in  6  R-type function field (instr[5:0])
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete (used only when MC_MEM_WAIT_EN defined)
- pcen  out  1  PC register enable
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select: 0=PC, 1=rs
- alusrcb  out  2  ALU B select: 00=rt, 01=4, 10=signimm, 11=signimm<<2
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memtoreg  out  1  writeback select: 0=ALUOut, 1=memdata
- regdst  out  1  destination select: 0=rt, 1=rd
- pcsrc  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- alucont  out  3  ALU operation code
- illegal  out  1  one-cycle pulse on unsupported op/funct

Function
REQ-002 Moore FSM, states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX; one transition per clk unless stalled.
REQ-003 Transitions: FETCH->DECODE; DECODE by op: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, other->FETCH.
REQ-004 MEMADR->MEMRD if op=100011, else MEMWR; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX->FETCH.
REQ-005 Control outputs are 0 in every state except as listed: FETCH: irwrite=1, pcwrite=1, alusrcb=01; DECODE: alusrcb=11; MEMADR/ADDIEX: alusrca=1, alusrcb=10; MEMRD: iord=1; MEMWB: memtoreg=1, regwrite=1; MEMWR: iord=1, memwrite=1; RTYPEEX: alusrca=1, aluop=10; RTYPEWB: regdst=1, regwrite=1; BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1; ADDIWB: regwrite=1; JEX: pcsrc=10, pcwrite=1.
REQ-006 pcen = pcwrite | (branch & zero), combinational; zero sampled in BEQEX only.
REQ-007 alucont decode: aluop 00->010 (add); 01->110 (sub); 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; code 011 never driven.
REQ-008 Unsupported funct in RTYPEEX SHALL drive alucont=010, suppress regwrite in the following RTYPEWB, and pulse illegal in RTYPEEX.
REQ-009 Unsupported op in DECODE SHALL pulse illegal for that cycle and return to FETCH (instruction treated as nop).
REQ-010 Instruction latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles with no stalls.

Reset
REQ-011 reset SHALL force state FETCH asynchronously, mid-instruction included; no write strobe completes after reset assertion.
REQ-012 While reset is high all outputs SHALL be 0 except alucont=010 and alusrcb=00; first FETCH outputs appear in the first cycle after reset deasserts.

Configuration
REQ-013 With MC_MEM_WAIT_EN defined: FETCH, MEMRD and MEMWR hold until mem_ready=1; in FETCH, irwrite and pcwrite assert only in the cycle mem_ready=1; memwrite and iord stay asserted throughout the MEMWR wait.
REQ-014 Without MC_MEM_WAIT_EN: mem_ready is ignored and memory is single-cycle per REQ-010.

Structure
REQ-015 Package mc_pkg SHALL hold the state enum, opcode and funct constants, the aluop type, and the alucont codes (shared with the ALU).
REQ-016 ALU decoding SHALL be a sub-module mc_aludec (aluop, funct -> alucont, illegal_funct); the FSM stays in mc_controller.

Verification
REQ-017 Bench SHALL cover:
- reset, then lw (op=100011) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
- R-type sub (funct=100010) -> alucont=110 in RTYPEEX; regdst=1, regwrite=1 in RTYPEWB.
- beq with zero=1, then zero=0 -> pcen=1 and pcsrc=01 in BEQEX; pcen=0 in the second case.
- op=111111 -> illegal=1 in DECODE, state FETCH next cycle; funct=000000 in R-type -> illegal pulse, no regwrite.
- reset asserted during MEMWR -> memwrite drops immediately; state FETCH after release.
- MC_MEM_WAIT_EN, sw with mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles, then FETCH.
